// File: rtl/jtag_mem_bridge_if.sv
// Signal bundle between the debug module, the bridge and the system bus.
// The slave modport is the bridge's view; master is the surrounding environment.
interface jtag_mem_bridge_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] mem_rdata_o;
  logic        rsp_err_o;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        busy_o;

  modport slave (
    input  req_valid_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    input  rsp_ready_i, bus_gnt_i, bus_rdata_i, bus_ack_i,
    output req_ready_o, rsp_valid_o, mem_rdata_o, rsp_err_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, busy_o
  );

  modport master (
    output req_valid_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    output rsp_ready_i, bus_gnt_i, bus_rdata_i, bus_ack_i,
    input  req_ready_o, rsp_valid_o, mem_rdata_o, rsp_err_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, busy_o
  );
endinterface

// File: rtl/jtag_mem_bridge.sv
// Debug-module memory request to system-bus master bridge: one request at a
// time, bus arbitration, ack wait with timeout abort, held response.
module jtag_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst_n,
  jtag_mem_bridge_if.slave mif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_RSP
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] lane_mask;
  logic [31:0] rsp_data;
  logic [15:0] cnt_inc;
  logic        timeout;
  logic        bus_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane_mask[i*8 +: 8] = {8{sel_q[i]}};
    end
    rsp_data = we_q ? '0 : (mif.bus_rdata_i & lane_mask);
    cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    // The counter reaches TIMEOUT_CYCLES on the edge that leaves for RSP.
    timeout  = (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (mif.req_valid_i) begin
          we_d    = mif.mem_we_i;
          addr_d  = mif.mem_addr_i;
          wdata_d = mif.mem_wdata_i;
          sel_d   = mif.mem_sel_i;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (mif.bus_gnt_i && mif.bus_ack_i) begin
          rdata_d = rsp_data;
          err_d   = 1'b0;
          state_d = S_RSP;
        end else if (timeout) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = S_RSP;
        end else if (mif.bus_gnt_i) begin
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_inc;
        if (mif.bus_ack_i) begin
          rdata_d = rsp_data;
          err_d   = 1'b0;
          state_d = S_RSP;
        end else if (timeout) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (mif.rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_active      = (state_q == S_REQ) || (state_q == S_WAIT_ACK);

  assign mif.req_ready_o = (state_q == S_IDLE);
  assign mif.rsp_valid_o = (state_q == S_RSP);
  assign mif.mem_rdata_o = rdata_q;
  assign mif.rsp_err_o   = err_q;
  assign mif.busy_o      = (state_q != S_IDLE);
  assign mif.bus_req_o   = (state_q == S_REQ);
  assign mif.bus_we_o    = bus_active & we_q;
  assign mif.bus_addr_o  = bus_active ? (addr_q & 32'hFFFF_FFFC) : '0;
  assign mif.bus_wdata_o = bus_active ? wdata_q : '0;
  assign mif.bus_sel_o   = bus_active ? sel_q : '0;

endmodule

// File: doc/jtag_mem_bridge.md
# jtag_mem_bridge

Bridges the debug module's memory-access handshake onto the system bus as a bus master. It sits directly downstream of the JTAG debug top: it accepts one request at a time on the req/rsp handshake, arbitrates for the bus, and waits for the slave acknowledge. It returns read data, or an error on timeout, to the debug module.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 256: cycles from entering REQ until abort; legal range 2..65535.
- `ERR_RDATA`, 32'h0000_0000: read data returned on timeout.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: debug-side request valid.
- `req_ready_o` out 1: bridge can accept a request.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_addr_i` in 32: byte address.
- `mem_wdata_i` in 32: write data.
- `mem_sel_i` in 4: byte enables; bit n selects byte lane n.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: debug side accepts the response.
- `mem_rdata_o` out 32: response read data.
- `rsp_err_o` out 1: response is a timeout error.
- `bus_req_o` out 1: bus request to the arbiter.
- `bus_gnt_i` in 1: arbiter grant.
- `bus_we_o` out 1: bus write enable.
- `bus_addr_o` out 32: word-aligned bus address.
- `bus_wdata_o` out 32: bus write data.
- `bus_sel_o` out 4: bus byte enables.
- `bus_rdata_i` in 32: slave read data, valid with `bus_ack_i`.
- `bus_ack_i` in 1: slave completion.
- `busy_o` out 1: high in every state except IDLE.

## Operation
The bridge is a four-state FSM: IDLE, REQ, WAIT_ACK, RSP.

**IDLE**
- `req_ready_o` = 1.
- On `req_valid_i`, capture `we`, addr, wdata and sel into holding registers.
- Clear the timeout counter and go to REQ.

**REQ**
- `bus_req_o` = 1. Bus outputs drive the held values:
  - `bus_addr_o` = {addr[31:2], 2'b00}.
  - `bus_sel_o` = sel.
  - `bus_wdata_o` = wdata.
- The counter increments every cycle.
- Grant without ack: go to WAIT_ACK.
- `bus_gnt_i` and `bus_ack_i` in the same cycle: capture the response and go straight to RSP.

**WAIT_ACK**
- `bus_req_o` = 0; bus address, data and sel outputs stay held.
- The counter keeps incrementing. On `bus_ack_i`, capture the response and go to RSP.

**Response capture**
- Read: `mem_rdata_o` = `bus_rdata_i` with unselected byte lanes forced to 0.
- Write: `mem_rdata_o` = 0.
- `rsp_err_o` = 0.

**Timeout**
- In REQ or WAIT_ACK, when the counter reaches `TIMEOUT_CYCLES` with no ack that cycle: `bus_req_o` drops.
- `mem_rdata_o` = `ERR_RDATA`, `rsp_err_o` = 1, go to RSP.
- An ack arriving in the same cycle as the timeout wins: normal response.

**RSP**
- `rsp_valid_o` = 1, with data and err held stable.
- On `rsp_ready_i`, go to IDLE.
- A late `bus_ack_i` in RSP or IDLE is ignored.

**Other rules**
- Requests with `mem_sel_i` = 0 still run a bus cycle.
- The bridge never checks alignment; `mem_addr_i[1:0]` is discarded.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready_o` = 1; every other output = 0.
  - Holding registers and counter = 0.
- Handshake rules:
  - `req_ready_o` is a pure function of state (IDLE).
  - `rsp_valid_o` never drops without `rsp_ready_i`.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Latency, from the accept edge to `rsp_valid_o` high, with grant and ack both immediate:
  - Grant and ack in the same cycle: 2 cycles.
  - Ack one cycle after grant: 3 cycles.
- Timeout: `rsp_valid_o` rises `TIMEOUT_CYCLES`+1 cycles after the accept edge.
- The counter is 16 bits and saturates; no wrap-around is possible within the legal parameter range.
- Reset mid-operation: `rst_n` low immediately drops `bus_req_o` and `rsp_valid_o` and returns to IDLE. Any in-flight transaction is discarded with no response.
- Back-to-back flow (req_valid held high, rsp_ready high, grant and ack immediate): one transaction every 3 cycles.

## Test plan
- **Read**: addr 0x1000_0006, sel 4'b1111, grant and ack in the same cycle, `bus_rdata_i` = 0xA5A5_1234.
  - Expect `bus_addr_o` = 0x1000_0004 and `rsp_valid_o` 2 cycles after accept.
  - Expect `mem_rdata_o` = 0xA5A5_1234, `rsp_err_o` = 0.
- **Masked read**: sel 4'b0100, `bus_rdata_i` = 0x1122_3344 → `mem_rdata_o` = 0x0022_0000.
- **Write with delayed grant**: wdata 0xDEAD_BEEF, sel 4'b0011, grant withheld 5 cycles, ack 2 cycles after grant.
  - Expect `bus_req_o` high for exactly 6 cycles, then `bus_we_o` = 1 with `bus_wdata_o` and `bus_sel_o` held until ack.
  - Expect the response to have `rsp_err_o` = 0.
- **Timeout**: `TIMEOUT_CYCLES` = 8, no grant.
  - Expect `rsp_valid_o` 9 cycles after accept, `rsp_err_o` = 1, `mem_rdata_o` = `ERR_RDATA`.
  - Then a late ack → no second response.
- **Response backpressure**: hold `rsp_ready_i` low for 4 cycles → `rsp_valid_o`, data and err stay stable and `req_ready_o` stays 0; `rsp_ready_i` high → IDLE next cycle.
- **Reset in WAIT_ACK**: assert `rst_n` low → all outputs at reset values immediately; after release, a fresh read completes normally.
